fetch_unit: RTL and testbench

Program-counter and IF/ID-latch controller for the fetch stage; sits directly upstream of the `memory` instruction memory, driving its word address and consuming its registered `data` output one cycle later. It handles sequential fetch, stall hold, and taken-branch redirect with flush. It presents an aligned instruction / next-PC / valid triple to decode.

---
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Fetch-stage PC and IF/ID latch controller.
// Drives a registered-read instruction memory and presents instr / next-PC / valid to decode.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_data,
   output logic [31:0] if_instr,
   output logic [31:0] if_npc,
   output logic        if_valid,
   output logic [31:0] fetch_count
);

   typedef enum logic [1:0] {
      EDGE_RUN      = 2'd0,
      EDGE_HOLD     = 2'd1,
      EDGE_REDIRECT = 2'd2
   } edge_mode_t;

   edge_mode_t  mode;

   logic [31:0] pc_reg;
   logic [31:0] pc_next;
   logic [31:0] fetch_pc_reg;
   logic [31:0] fetch_pc_next;
   logic        fetch_v_reg;
   logic        fetch_v_next;
   logic [31:0] instr_reg;
   logic [31:0] instr_next;
   logic [31:0] npc_reg;
   logic [31:0] npc_next;
   logic        valid_reg;
   logic        valid_next;
   logic [31:0] count_reg;
   logic [31:0] count_next;

   // A redirect beats a stall; a stall re-presents the in-flight address so
   // the memory keeps that word on its output for the release edge.
   always_comb begin
      mode = EDGE_RUN;
      if (branch_taken) begin
         mode = EDGE_REDIRECT;
      end else if (stall) begin
         mode = EDGE_HOLD;
      end
   end

   always_comb begin
      mem_addr = pc_reg;
      case (mode)
         EDGE_REDIRECT: mem_addr = branch_target;
         EDGE_HOLD:     mem_addr = fetch_pc_reg;
         default:       mem_addr = pc_reg;
      endcase
   end

   always_comb begin
      pc_next       = pc_reg;
      fetch_pc_next = fetch_pc_reg;
      fetch_v_next  = fetch_v_reg;
      instr_next    = instr_reg;
      npc_next      = npc_reg;
      valid_next    = valid_reg;
      count_next    = count_reg;
      case (mode)
         EDGE_REDIRECT: begin
            // Both the in-flight and the latched word are wrong-path.
            valid_next    = 1'b0;
            fetch_pc_next = branch_target;
            fetch_v_next  = 1'b1;
            pc_next       = branch_target + 32'd1;
         end
         EDGE_RUN: begin
            instr_next    = mem_data;
            npc_next      = fetch_pc_reg + 32'd1;
            valid_next    = fetch_v_reg;
            fetch_pc_next = pc_reg;
            fetch_v_next  = 1'b1;
            pc_next       = pc_reg + 32'd1;
            if (fetch_v_reg) begin
               count_next = count_reg + 32'd1;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_reg       <= RESET_PC;
         fetch_pc_reg <= 32'd0;
         fetch_v_reg  <= 1'b0;
         instr_reg    <= 32'd0;
         npc_reg      <= 32'd0;
         valid_reg    <= 1'b0;
         count_reg    <= 32'd0;
      end else begin
         pc_reg       <= pc_next;
         fetch_pc_reg <= fetch_pc_next;
         fetch_v_reg  <= fetch_v_next;
         instr_reg    <= instr_next;
         npc_reg      <= npc_next;
         valid_reg    <= valid_next;
         count_reg    <= count_next;
      end
   end

   assign if_instr    = instr_reg;
   assign if_npc      = npc_reg;
   assign if_valid    = valid_reg;
   assign fetch_count = count_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected words, a monitor
// pops them on every delivery edge and also tracks valid/count timing.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'd0;
   logic [31:0] mem_addr;
   logic [31:0] mem_data = 32'd0;
   logic [31:0] if_instr;
   logic [31:0] if_npc;
   logic        if_valid;
   logic [31:0] fetch_count;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] npc;
   } exp_t;
   exp_t exp_q[$];

   fetch_unit #(.RESET_PC(32'd0)) dut (
      .clk(clk),
      .rst(rst),
      .stall(stall),
      .branch_taken(branch_taken),
      .branch_target(branch_target),
      .mem_addr(mem_addr),
      .mem_data(mem_data),
      .if_instr(if_instr),
      .if_npc(if_npc),
      .if_valid(if_valid),
      .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [3:0] n;
      n = a[3:0];
      if (a == 32'd0) return 32'hA00000AA;
      if (a <= 32'd9) return {n, 20'h00000, n, n};
      return {16'hDEAD, a[15:0]};
   endfunction

   // Instruction memory with registered read.
   always @(posedge clk) mem_data <= mem_word(mem_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_word(input int n);
      exp_t e;
      e.instr = mem_word(n);
      e.npc   = n + 1;
      exp_q.push_back(e);
   endtask

   // Timing model: which edges load if_valid, and with what.
   logic        m_fv = 1'b0;
   logic        m_valid = 1'b0;
   logic        m_load = 1'b0;
   logic [31:0] m_cnt = 32'd0;
   exp_t        last_exp = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_fv <= 1'b0; m_valid <= 1'b0; m_load <= 1'b0; m_cnt <= 32'd0;
      end else if (branch_taken) begin
         m_fv <= 1'b1; m_valid <= 1'b0; m_load <= 1'b0;
      end else if (!stall) begin
         m_valid <= m_fv;
         m_load  <= m_fv;
         m_cnt   <= m_cnt + (m_fv ? 32'd1 : 32'd0);
         m_fv    <= 1'b1;
      end else begin
         m_load <= 1'b0;
      end
   end

   always @(negedge clk) begin
      chk("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
      chk("fetch_count", fetch_count, m_cnt);
      if (m_load) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_delivery", if_instr, 32'hFFFF_FFFF);
         end else begin
            last_exp = exp_q.pop_front();
            $display("deliver instr=%h npc=%0d count=%0d", if_instr, if_npc, fetch_count);
            chk("if_instr", if_instr, last_exp.instr);
            chk("if_npc", if_npc, last_exp.npc);
         end
      end else if (m_valid) begin
         chk("hold_instr", if_instr, last_exp.instr);
         chk("hold_npc", if_npc, last_exp.npc);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_zero_and_drained();
      chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_if_instr", if_instr, 32'd0);
      chk("rst_if_npc", if_npc, 32'd0);
      chk("rst_fetch_count", fetch_count, 32'd0);
      chk("queue_drained", exp_q.size(), 32'd0);
   endtask

   // Called at a negedge; asserts reset between edges, releases at next negedge.
   task automatic do_reset();
      #2 rst = 1'b1;
      #1 check_zero_and_drained();
      stall = 1'b0;
      branch_taken = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic free_run();
      for (int i = 0; i < 5; i++) push_word(i);
      tick(6);
      chk("s1_count", fetch_count, 32'd5);
      chk("s1_last_instr", if_instr, 32'h40000044);
   endtask

   initial begin
      tick(2);
      rst = 1'b0;
      $display("scenario free-run");
      free_run();

      do_reset();
      $display("scenario stall");
      for (int i = 0; i < 5; i++) push_word(i);
      tick(4);
      stall = 1'b1;
      #1 chk("stall_mem_addr", mem_addr, 32'd3);
      tick(3);
      stall = 1'b0;
      tick(2);
      chk("s2_count", fetch_count, 32'd5);

      do_reset();
      $display("scenario branch");
      push_word(0); push_word(1); push_word(8); push_word(9);
      tick(3);
      branch_taken = 1'b1; branch_target = 32'd8;
      #1 chk("br_mem_addr", mem_addr, 32'd8);
      tick(1);
      branch_taken = 1'b0;
      tick(2);
      chk("s3_count", fetch_count, 32'd4);

      do_reset();
      $display("scenario branch+stall");
      push_word(0); push_word(1); push_word(5); push_word(6);
      tick(3);
      branch_taken = 1'b1; stall = 1'b1; branch_target = 32'd5;
      #1 chk("brst_mem_addr", mem_addr, 32'd5);
      tick(1);
      branch_taken = 1'b0; stall = 1'b0;
      tick(2);
      chk("s4_count", fetch_count, 32'd4);

      do_reset();
      $display("scenario back-to-back branches");
      push_word(0); push_word(1); push_word(7); push_word(8);
      tick(3);
      branch_taken = 1'b1; branch_target = 32'd2;
      tick(1);
      branch_target = 32'd7;
      #1 chk("b2b_mem_addr", mem_addr, 32'd7);
      tick(1);
      branch_taken = 1'b0;
      tick(2);
      chk("s5_count", fetch_count, 32'd4);

      do_reset();
      $display("scenario branch to in-flight pc");
      push_word(0); push_word(1); push_word(2); push_word(3);
      tick(3);
      branch_taken = 1'b1; branch_target = 32'd2;
      tick(1);
      branch_taken = 1'b0;
      tick(2);
      chk("s6_count", fetch_count, 32'd4);

      do_reset();
      $display("scenario async reset mid-stall");
      push_word(0); push_word(1); push_word(2);
      tick(4);
      stall = 1'b1;
      tick(1);
      #3 rst = 1'b1;
      #1 check_zero_and_drained();
      stall = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      free_run();

      do_reset();
      tick(1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
